popcount_arbiter: RTL and testbench
===================================

// Module: popcount_arbiter
// PURPOSE
//  Shares one bit-serial OnesCount engine among N requesters.
//  - Arbitrates among requesters round-robin.
//  - Latches the winner's operand and issues it to the engine with a 1-cycle start.
//  - Waits for the engine's done pulse and returns the count, tagged with the winner's id.
//  - Sits between client FSMs and the engine; a watchdog guards against a hung engine.
// PARAMETERS
//  W        30            operand width (engine d_in width)
//  N        4             number of requesters, N>=2
//  TIMEOUT  64            WAIT cycles before declaring engine hang, TIMEOUT>W+2
//  CW       $clog2(W+1)   count width (derived, not overridden)
//  IW       $clog2(N)     requester id width (derived)
// PORTS
//  clock          in   1     rising-edge clock
//  reset          in   1     synchronous, active-high
//  req            in   N     req[i]=1: requester i wants a count; level, held until ack[i]
//  req_data       in   N*W   operand i at req_data[i*W +: W]; stable while req[i]=1
//  ack            out  N     one-hot 1-cycle pulse: transaction for requester i done
//  resp_valid     out  1     1-cycle pulse, coincident with ack
//  resp_id        out  IW    index of requester being answered
//  resp_count     out  CW    popcount result; 0 when resp_err=1
//  resp_err       out  1     1 = engine timed out for this transaction
//  busy           out  1     1 in every state except IDLE
//  eng_d_in_ready out  1     start strobe to engine, exactly 1 cycle per transaction
//  eng_d_in       out  W     operand to engine, registered, stable from ISSUE to RESP
//  eng_d_out_ready in  1     engine done pulse
//  eng_d_out      in   CW    engine result, valid while eng_d_out_ready=1
// BEHAVIOUR
//  Reset (sync): state=IDLE; last=N-1 so requester 0 has first priority.
//   All outputs 0, including eng_d_in; the grant, timer and result registers clear.
//   Reset mid-transaction abandons it: no ack is issued, and a late engine done is ignored in IDLE.
//  FSM, 4 states:
//   IDLE: if |req, grant g = first set req[] searching last+1, last+2, ... mod N.
//    Latch eng_d_in<=req_data[g], grant<=g, go ISSUE. Else stay.
//   ISSUE: eng_d_in_ready=1 for this cycle only; timer<=0; go WAIT.
//    An eng_d_out_ready seen in ISSUE is ignored.
//   WAIT: if eng_d_out_ready, result<=eng_d_out, err<=0, go RESP.
//    Else if timer==TIMEOUT-1, result<=0, err<=1, go RESP.
//    Else timer<=timer+1. Done has priority over timeout in the same cycle.
//   RESP: resp_valid=1, ack[grant]=1, resp_id=grant, resp_count=result, resp_err=err.
//    last<=grant; go IDLE.
//  Outputs: resp_*/ack are registered state decodes, 0 outside RESP.
//   resp_id and resp_count hold their last value but are meaningful only with resp_valid.
//  Latency: req sampled in IDLE cycle t; start strobe in t+1.
//   If engine done arrives in cycle t+1+k (k>=1), ack occurs in t+2+k.
//   Minimum gap between acks: 4 cycles.
//  Handshake rules:
//   - A requester drops req[i] at the edge ending its ack cycle.
//   - req[i] still high in the following IDLE cycle is a new request.
//   - Requests arriving while busy wait; they are not lost or queued beyond the level req.
//   - req[g] dropping mid-transaction does not abort it; ack[g] is still issued.
//  Fairness: with all req high, grants rotate 0,1,..,N-1,0.
//   The last-granted requester has lowest priority in the next arbitration.
//   Last-granted pointer wraps N-1 -> 0.
//  Widths: timer is $clog2(TIMEOUT) bits. resp_count is passed through unmodified (0..W).
// TESTING
//  1. req=0001, data0=30'h3 -> eng_d_in=3, one start pulse; engine done count 2.
//     -> ack=0001, resp_id=0, resp_count=2, resp_err=0.
//  2. req=1111 held high with each req re-raised after ack -> grant order 0,1,2,3,0.
//     -> acks spaced >= 4 cycles apart.
//  3. data=30'h3FFFFFFF, engine done count 30 -> resp_count=30.
//     data=0, count 0 -> resp_count=0; width boundary.
//  4. Engine never signals done -> RESP exactly TIMEOUT WAIT cycles after ISSUE.
//     -> resp_err=1, resp_count=0; next request is served normally.
//  5. Done pulse in the same cycle as timer==TIMEOUT-1 -> resp_err=0, count captured.
//  6. Reset asserted during WAIT -> next cycle IDLE, all outputs 0, no ack.
//     A late eng_d_out_ready is ignored; the following req=0100 is granted to id 2.

Source files
------------

// File: rtl/popcount_arbiter.sv
// Round-robin front end that shares one bit-serial popcount engine among N requesters,
// with a watchdog that answers with an error if the engine never reports done.
module popcount_arbiter #(
    parameter  int W       = 30,
    parameter  int N       = 4,
    parameter  int TIMEOUT = 64,
    localparam int CW      = $clog2(W + 1),
    localparam int IW      = $clog2(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  req_data,
    output logic [N-1:0]    ack,
    output logic            resp_valid,
    output logic [IW-1:0]   resp_id,
    output logic [CW-1:0]   resp_count,
    output logic            resp_err,
    output logic            busy,
    output logic            eng_d_in_ready,
    output logic [W-1:0]    eng_d_in,
    input  logic            eng_d_out_ready,
    input  logic [CW-1:0]   eng_d_out
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   result_q, result_d;
    logic            err_q, err_d;
    logic [W-1:0]    d_in_q, d_in_d;

    logic [W-1:0]    ops [N];
    logic            win_found;
    logic [IW-1:0]   win_id;

    // Search starts just after the last winner, so that winner drops to lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < N; i++) begin
            ops[i] = req_data[i*W +: W];
        end
        for (int i = 1; i <= N; i++) begin
            if (!win_found && req[IW'((int'(last_q) + i) % N)]) begin
                win_found = 1'b1;
                win_id    = IW'((int'(last_q) + i) % N);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        grant_d  = grant_q;
        timer_d  = timer_q;
        result_d = result_q;
        err_d    = err_q;
        d_in_d   = d_in_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    d_in_d  = ops[win_id];
                    grant_d = win_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done pulse wins over the watchdog expiring in the same cycle.
                if (eng_d_out_ready) begin
                    result_d = eng_d_out;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= IW'(N - 1);
            grant_q  <= '0;
            timer_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            d_in_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            err_q    <= err_d;
            d_in_q   <= d_in_d;
        end
    end

    always_comb begin
        ack = '0;
        if (state_q == RESP) begin
            ack[grant_q] = 1'b1;
        end
    end

    assign resp_valid     = (state_q == RESP);
    assign resp_id        = grant_q;
    assign resp_count     = result_q;
    assign resp_err       = (state_q == RESP) && err_q;
    assign busy           = (state_q != IDLE);
    assign eng_d_in_ready = (state_q == ISSUE);
    assign eng_d_in       = d_in_q;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Scoreboard bench for popcount_arbiter: stimulus pushes expected responses,
// a monitor pops and compares them, and a behavioural engine answers start strobes.
module tb_popcount_arbiter;
    localparam int W       = 30;
    localparam int N       = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(W + 1);
    localparam int IW      = $clog2(N);

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    ack;
    logic            resp_valid;
    logic [IW-1:0]   resp_id;
    logic [CW-1:0]   resp_count;
    logic            resp_err;
    logic            busy;
    logic            eng_d_in_ready;
    logic [W-1:0]    eng_d_in;
    logic            eng_d_out_ready;
    logic [CW-1:0]   eng_d_out;

    popcount_arbiter #(.W(W), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .req_data       (req_data),
        .ack            (ack),
        .resp_valid     (resp_valid),
        .resp_id        (resp_id),
        .resp_count     (resp_count),
        .resp_err       (resp_err),
        .busy           (busy),
        .eng_d_in_ready (eng_d_in_ready),
        .eng_d_in       (eng_d_in),
        .eng_d_out_ready(eng_d_out_ready),
        .eng_d_out      (eng_d_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [W-1:0] data;
        int          cnt;
        bit          err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pend[N];
    int   eng_delay = 1;
    bit   eng_hang = 1'b0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   strobes = 0;
    int   last_ack_cyc = -100;
    exp_t mon_e;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) if (pend[i] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic issue(input int id, input logic [W-1:0] d, input int cnt, input bit err,
                         input int lat);
        exp_t e;
        req_data[id*W +: W] = d;
        e.id = id; e.data = d; e.cnt = cnt; e.err = err; e.lat = lat;
        sb.push_back(e);
        pend[id]++;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((sb.size() != 0 || busy || any_pend()) && n < max) begin
            @(negedge clock);
            n++;
        end
        if (n >= max) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out after %0d cycles, %0d responses outstanding", name, n,
                     sb.size());
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_id"}, resp_id, 0);
        check({tag, "_resp_count"}, resp_count, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_eng_d_in_ready"}, eng_d_in_ready, 0);
        check({tag, "_eng_d_in"}, eng_d_in, 0);
    endtask

    // Requesters: hold req while transactions remain, drop it on the last ack.
    initial begin
        req = '0;
        for (int i = 0; i < N; i++) pend[i] = 0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                if (ack[i] && pend[i] > 0) pend[i]--;
                req[i] = (pend[i] > 0);
            end
        end
    end

    // Engine: answers a start strobe eng_delay cycles later with the operand's popcount.
    initial begin
        logic [CW-1:0] c;
        eng_d_out_ready = 1'b0;
        eng_d_out       = '0;
        forever begin
            @(negedge clock);
            if (eng_d_in_ready && !eng_hang) begin
                c = CW'($countones(eng_d_in));
                repeat (eng_delay) @(negedge clock);
                eng_d_out_ready = 1'b1;
                eng_d_out       = c;
                @(negedge clock);
                eng_d_out_ready = 1'b0;
                eng_d_out       = '0;
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (eng_d_in_ready) begin
                strobes++;
                start_cyc = cyc;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got id %0d, expected no response", resp_id);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack", ack, longint'(1) << mon_e.id);
                    check("resp_id", resp_id, mon_e.id);
                    check("resp_count", resp_count, mon_e.cnt);
                    check("resp_err", resp_err, mon_e.err);
                    check("latency", cyc - start_cyc, mon_e.lat);
                    check("start_pulses", strobes, 1);
                    check("eng_d_in", eng_d_in, mon_e.data);
                    check("ack_gap_ge4", (cyc - last_ack_cyc) >= 4, 1);
                end
                last_ack_cyc = cyc;
                strobes = 0;
            end else if (ack != '0) begin
                checks++;
                errors++;
                $display("FAIL ack_without_valid: got ack %b, expected 0", ack);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        req_data = '0;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b0;

        eng_delay = 3;
        issue(0, 30'h3, 2, 1'b0, 4);
        wait_drain("t1_drain", 200);

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        eng_delay = 1;
        issue(0, 30'h3, 2, 1'b0, 2);
        issue(1, 30'h0F0, 4, 1'b0, 2);
        issue(2, 30'h3FFFFFFF, 30, 1'b0, 2);
        issue(3, 30'h0, 0, 1'b0, 2);
        issue(0, 30'h3, 2, 1'b0, 2);
        wait_drain("t2_drain", 500);

        eng_delay = 2;
        issue(1, 30'h3FFFFFFF, 30, 1'b0, 3);
        wait_drain("t3_full_drain", 200);
        issue(3, 30'h0, 0, 1'b0, 3);
        wait_drain("t3_zero_drain", 200);

        eng_hang = 1'b1;
        issue(2, 30'h155, 0, 1'b1, TIMEOUT + 1);
        wait_drain("t4_timeout_drain", 400);
        eng_hang  = 1'b0;
        eng_delay = 1;
        issue(3, 30'hFF, 8, 1'b0, 2);
        wait_drain("t4_recover_drain", 200);

        eng_delay = TIMEOUT;
        issue(0, 30'h2AAAAAAA, 15, 1'b0, TIMEOUT + 1);
        wait_drain("t5_drain", 400);

        eng_delay = 10;
        issue(1, 30'h7, 3, 1'b0, 11);
        n = 0;
        while (!eng_d_in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL t6_strobe: no start strobe within %0d cycles", n);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 0;
        req = '0;
        sb.delete();
        strobes = 0;
        @(negedge clock);
        check_outputs_zero("t6_reset");
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("t6_late_done_busy", busy, 0);
        eng_delay = 2;
        issue(2, 30'hF0F, 8, 1'b0, 3);
        wait_drain("t6_next_drain", 200);

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
